keyboard_event_queue: RTL and testbench
=======================================

Name: keyboard_event_queue

Overview:
Parametrised keyboard matrix front end. It round-robin scans NUM_KEYS raw key lines and debounces each key by time-multiplexed sampling. Each debounced press or release becomes an event {pressed, index}, which is queued in an internal FIFO. Events are delivered to the host/report logic over a valid/ready handshake, so no event is lost while the consumer is stalled.

Parameters:
NUM_KEYS, 104, number of key inputs scanned (2..128)
IDX_W, 7, key index width; 2**IDX_W >= NUM_KEYS required
DEB_SAMPLES, 4, consecutive identical scan visits needed to accept a level change (2..15)
FIFO_DEPTH, 16, event queue entries, power of two (2..64)
ACTIVE_LOW, 1, 1 = key_raw low means pressed

Ports:
clock  input  1  system clock
reset  input  1  reset; asynchronous, active-high
key_raw  input  NUM_KEYS  raw key lines, asynchronous to clock
scan_en  input  1  1 = scan pointer advances
ev_valid  output  1  FIFO head holds an event
ev_data  output  IDX_W+1  {pressed, key index} at FIFO head
ev_ready  input  1  consumer accepts head this cycle
ev_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky: at least one event was deferred because the FIFO was full
clr_ovf  input  1  synchronous clear of overflow

Behaviour:
- Reset (async) values: scan pointer 0; all per-key stable states = released; all per-key counters 0; synchronizers 0 (interpreted after polarity); FIFO empty; ev_valid 0; ev_data 0; ev_level 0; overflow 0.
- Input path: 2-flop synchronizer on every key_raw bit. Polarity is applied after the synchronizer: pressed = ACTIVE_LOW ? ~sync : sync.
- Scan pointer ptr: when scan_en=1, increments each cycle and wraps NUM_KEYS-1 -> 0. When scan_en=0, ptr holds and no key is evaluated.
- One key, ptr, is evaluated per enabled cycle:
  - sample == stable[ptr]: cnt[ptr] <= 0.
  - sample != stable[ptr] and cnt[ptr] < DEB_SAMPLES-1: cnt[ptr] increments.
  - sample != stable[ptr] and cnt[ptr] == DEB_SAMPLES-1: accept, i.e. push {sample, ptr} to the FIFO, toggle stable[ptr], cnt[ptr] <= 0.
  - A single differing visit followed by a matching visit restarts the count; glitches shorter than DEB_SAMPLES visits produce no event.
- Push rule: push allowed if FIFO not full, or if full and a pop occurs in the same cycle.
  - If push is refused: stable[ptr] is not toggled, cnt[ptr] stays at DEB_SAMPLES-1, overflow <= 1. The key re-attempts on its next visit, so the event is delayed, never lost.
- FIFO is first-word-fall-through. ev_valid = (level != 0). ev_data = head entry when valid, else 0.
  - Pop occurs when ev_valid & ev_ready.
  - Push into an empty FIFO: ev_valid rises the cycle after the push edge.
  - Simultaneous push and pop: level unchanged, ordering preserved.
  - ev_ready while empty: ignored.
- overflow is cleared by clr_ovf. If a refused push and clr_ovf happen in the same cycle, set wins.
- Worst-case latency from a stable key change to ev_valid (FIFO not full, scan_en=1): 2 + DEB_SAMPLES*NUM_KEYS + 1 cycles.
- Reset mid-operation: all state returns to reset values at once, and queued events are discarded. Keys still held after reset are re-reported as presses after debounce.
- Events are in scan order. Each key's events always alternate press/release.

Test Plan:
- Reset check (NUM_KEYS=8, IDX_W=3, DEB_SAMPLES=3, FIFO_DEPTH=4): assert reset mid-run -> ev_valid=0, ev_data=0, ev_level=0, overflow=0 without waiting for a clock edge.
- Press: key_raw[5]=0 held, ev_ready=1 -> exactly one event ev_data=4'hD within 2+3*8+1=27 cycles, then no further events.
- Release: then key_raw[5]=1 -> one event 4'h5. A glitch on key 2 low for 2 visits only -> no event.
- Overflow/no loss: ev_ready=0, press keys 0..5 -> ev_level=4 with events 8,9,A,B, overflow=1. Then ev_ready=1 -> drain 8,9,A,B, followed by C,D; no duplicates.
- Simultaneous push/pop with FIFO full: pop and accept on the same edge -> level stays 4, order preserved. clr_ovf=1 -> overflow=0.
- scan_en=0 while a key changes -> no events and ptr frozen. Re-enable -> event after DEB_SAMPLES visits.

Source files
------------

// File: rtl/keyboard_event_queue.sv
// keyboard_event_queue: round-robin key scanner with per-key debounce feeding a first-word-fall-through event FIFO
// Ports: clock, reset (async, active-high); key_raw raw key lines; scan_en advances the scan pointer;
//        ev_valid/ev_data/ev_ready event handshake, ev_data = {pressed, key index}; ev_level FIFO occupancy;
//        overflow sticky flag for a deferred event, cleared by clr_ovf.
module keyboard_event_queue #(
   parameter int NUM_KEYS    = 104,
   parameter int IDX_W       = 7,
   parameter int DEB_SAMPLES = 4,
   parameter int FIFO_DEPTH  = 16,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_KEYS-1:0]           key_raw,
   input  logic                          scan_en,
   output logic                          ev_valid,
   output logic [IDX_W:0]                ev_data,
   input  logic                          ev_ready,
   output logic [$clog2(FIFO_DEPTH):0]   ev_level,
   output logic                          overflow,
   input  logic                          clr_ovf
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_KEYS - 1);
   localparam logic [3:0] DEB_MAX = 4'(DEB_SAMPLES - 1);
   localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
   logic [NUM_KEYS-1:0] sync1, sync2, stable;
   logic [3:0] cnt [NUM_KEYS];
   logic [IDX_W-1:0] ptr;
   logic [IDX_W:0] mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic sample, differ, accept, push, pop;
   always_comb begin
      sample   = (ACTIVE_LOW != 0) ? ~sync2[ptr] : sync2[ptr];
      differ   = sample != stable[ptr];
      accept   = scan_en & differ & (cnt[ptr] == DEB_MAX);
      ev_valid = ev_level != '0;
      pop      = ev_valid & ev_ready;
      // a full queue can still take the event when the head leaves on the same edge
      push     = accept & ((ev_level != FULL) | pop);
      ev_data  = ev_valid ? mem[rd_ptr] : '0;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         sync1    <= '0;
         sync2    <= '0;
         stable   <= '0;
         ptr      <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         ev_level <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
         if (scan_en) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
            if (!differ) cnt[ptr] <= '0;
            else if (cnt[ptr] != DEB_MAX) cnt[ptr] <= cnt[ptr] + 1'b1;
            // a refused push leaves the counter saturated so the key retries on its next visit
            else if (push) begin
               stable[ptr] <= ~stable[ptr];
               cnt[ptr]    <= '0;
            end
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         ev_level <= ev_level + LW'(push) - LW'(pop);
         overflow <= (accept & ~push) | (overflow & ~clr_ovf);
      end
   always_ff @(posedge clock)
      if (push) mem[wr_ptr] <= {sample, ptr};
endmodule

// File: tb/tb_keyboard_event_queue.sv
// tb_keyboard_event_queue: directed and randomized checks of the key scanner event queue
module tb_keyboard_event_queue;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [7:0] key_raw = '1;
   logic scan_en = 1'b1;
   logic ev_ready = 1'b0;
   logic clr_ovf = 1'b0;
   logic ev_valid;
   logic [3:0] ev_data;
   logic [2:0] ev_level;
   logic overflow;
   logic [2:0] tb_ptr = '0;
   int errors = 0;
   int checks = 0;
   int lat, n;
   logic [3:0] d;
   logic [7:0] cfg, rep, gm;
   keyboard_event_queue #(.NUM_KEYS(8), .IDX_W(3), .DEB_SAMPLES(3), .FIFO_DEPTH(4), .ACTIVE_LOW(1)) dut (
      .clock(clock), .reset(reset), .key_raw(key_raw), .scan_en(scan_en),
      .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready),
      .ev_level(ev_level), .overflow(overflow), .clr_ovf(clr_ovf)
   );
   always #5 clock = ~clock;
   // scan position the next enabled edge will evaluate, used only to line stimulus up with visits
   always @(posedge clock or posedge reset)
      if (reset) tb_ptr <= '0;
      else if (scan_en) tb_ptr <= tb_ptr + 3'd1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick(input int c);
      repeat (c) @(negedge clock);
   endtask
   task automatic align(input logic [2:0] p);
      for (int i = 0; i < 8 && tb_ptr != p; i++) @(negedge clock);
   endtask
   task automatic wait_ev(input int budget, output int l, output logic [3:0] v);
      l = -1;
      v = '0;
      for (int i = 0; i <= budget; i++) begin
         if (ev_valid) begin
            l = i;
            v = ev_data;
            @(negedge clock);
            break;
         end
         @(negedge clock);
      end
   endtask
   task automatic count_ev(input int c, output int k);
      k = 0;
      repeat (c) begin
         @(negedge clock);
         if (ev_valid) k++;
      end
   endtask
   task automatic drain_expect(input string tag, input int cnt_n, input logic [3:0] first);
      int l;
      logic [3:0] v;
      for (int i = 0; i < cnt_n; i++) begin
         wait_ev(40, l, v);
         chk({tag, "_seen"}, l >= 0, 1);
         chk(tag, v, first + 4'(i));
      end
   endtask
   initial begin
      tick(3);
      chk("rst_valid", ev_valid, 0);
      chk("rst_data", ev_data, 0);
      chk("rst_level", ev_level, 0);
      chk("rst_ovf", overflow, 0);
      reset = 1'b0;
      tick(20);
      ev_ready = 1'b1;
      key_raw[5] = 1'b0;
      wait_ev(40, lat, d);
      chk("press_data", d, 4'hD);
      chk("press_latency", lat >= 1 && lat <= 27, 1);
      count_ev(60, n);
      chk("press_extra", n, 0);
      key_raw[5] = 1'b1;
      wait_ev(40, lat, d);
      chk("release_data", d, 4'h5);
      chk("release_latency", lat >= 1 && lat <= 27, 1);
      count_ev(30, n);
      chk("release_extra", n, 0);
      key_raw[2] = 1'b0;
      tick(16);
      key_raw[2] = 1'b1;
      count_ev(40, n);
      chk("glitch", n, 0);
      ev_ready = 1'b0;
      align(3'd6);
      key_raw[5:0] = '0;
      tick(60);
      chk("ovf_level", ev_level, 4);
      chk("ovf_flag", overflow, 1);
      chk("ovf_valid", ev_valid, 1);
      chk("ovf_head", ev_data, 4'h8);
      ev_ready = 1'b1;
      drain_expect("ovf_drain", 6, 4'h8);
      count_ev(40, n);
      chk("ovf_extra", n, 0);
      ev_ready = 1'b0;
      align(3'd6);
      key_raw[5:0] = '1;
      tick(60);
      chk("full_level", ev_level, 4);
      align(3'd4);
      chk("simul_head", ev_data, 4'h0);
      ev_ready = 1'b1;
      @(negedge clock);
      ev_ready = 1'b0;
      chk("simul_level", ev_level, 4);
      chk("simul_next", ev_data, 4'h1);
      clr_ovf = 1'b1;
      @(negedge clock);
      chk("set_wins", overflow, 1);
      @(negedge clock);
      chk("clr_ovf", overflow, 0);
      clr_ovf = 1'b0;
      ev_ready = 1'b1;
      drain_expect("simul_drain", 5, 4'h1);
      count_ev(40, n);
      chk("simul_extra", n, 0);
      align(3'd7);
      scan_en = 1'b0;
      key_raw[7] = 1'b0;
      count_ev(43, n);
      chk("scan_off", n, 0);
      scan_en = 1'b1;
      wait_ev(40, lat, d);
      chk("scan_on_data", d, 4'hF);
      chk("scan_on_latency", lat, 17);
      key_raw[7] = 1'b1;
      wait_ev(40, lat, d);
      chk("key7_release", d, 4'h7);
      ev_ready = 1'b0;
      align(3'd6);
      key_raw[5:0] = '0;
      tick(60);
      chk("pre_rst_level", ev_level, 4);
      #2 reset = 1'b1;
      #1;
      chk("midrst_valid", ev_valid, 0);
      chk("midrst_data", ev_data, 0);
      chk("midrst_level", ev_level, 0);
      chk("midrst_ovf", overflow, 0);
      @(negedge clock);
      reset = 1'b0;
      ev_ready = 1'b1;
      drain_expect("rereport", 6, 4'h8);
      count_ev(40, n);
      chk("rereport_extra", n, 0);
      key_raw = '1;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      cfg = '0;
      rep = '0;
      // random windows: each key that changes level must report exactly one event of the new level
      for (int w = 0; w < 25; w++) begin
         cfg = 8'($urandom);
         for (int c = 0; c < 210; c++) begin
            gm = (c == 30 || c == 70 || c == 110) ? 8'(1) << $urandom_range(0, 7) : 8'h00;
            key_raw = ~cfg ^ gm;
            ev_ready = (c >= 150) ? 1'b1 : 1'($urandom_range(0, 1));
            if (ev_valid && ev_ready) begin
               chk("rnd_pending", cfg[ev_data[2:0]] != rep[ev_data[2:0]], 1);
               chk("rnd_level", ev_data[3], cfg[ev_data[2:0]]);
               rep[ev_data[2:0]] = ev_data[3];
            end
            @(negedge clock);
         end
         chk("rnd_delivered", rep, cfg);
         chk("rnd_empty", ev_valid, 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
